// File: rtl/furv_mc.sv
// furv_mc: multi-cycle RV32I/RV32E core on one shared valid/ready memory port.
// FURV_MC_SUBWORD_EN enables byte/halfword loads and stores.
module furv_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        retire,
    output logic        halted
);
    localparam int AW = $clog2(NREGS);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic [31:0] rf_q [NREGS];
    logic        rf_we;
    logic [31:0] rf_wd;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rv1, rv2, alu_b, alu, ea, jt, pc4, wb, ld_data, st_data;
    logic [3:0]  st_strb;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence;
    logic        use_rd, use_rs1, use_rs2, bad_reg, op_ok, opi_ok, ld_ok, st_ok, legal;
    logic        br_take, jump, mis_tgt, mis_data, is_mem;
    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign is_lui   = opc == 7'h37;
    assign is_auipc = opc == 7'h17;
    assign is_jal   = opc == 7'h6F;
    assign is_jalr  = opc == 7'h67;
    assign is_br    = opc == 7'h63;
    assign is_ld    = opc == 7'h03;
    assign is_st    = opc == 7'h23;
    assign is_opi   = opc == 7'h13;
    assign is_op    = opc == 7'h33;
    assign is_fence = opc == 7'h0F;
    assign is_mem   = is_ld | is_st;
    assign rv1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[AW-1:0]];
    assign rv2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[AW-1:0]];
    // RV32E: any referenced register index with bit 4 set does not exist
    assign use_rd  = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op;
    assign use_rs1 = is_jalr | is_br | is_ld | is_st | is_opi | is_op;
    assign use_rs2 = is_br | is_st | is_op;
    assign bad_reg = (NREGS < 32) && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
    assign op_ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    assign opi_ok = (f3 == 3'd1) ? f7 == 7'h00 : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
`ifdef FURV_MC_SUBWORD_EN
    assign ld_ok = f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
    assign st_ok = !f3[2] && f3[1:0] != 2'd3;
    assign ld_data = f3[1] ? mem_rdata
                   : f3[0] ? {{16{~f3[2] & mem_rdata[{ea[1], 4'b0000} + 15]}}, mem_rdata[{ea[1], 4'b0000} +: 16]}
                   : {{24{~f3[2] & mem_rdata[{ea[1:0], 3'b000} + 7]}}, mem_rdata[{ea[1:0], 3'b000} +: 8]};
    assign st_data = f3[1] ? rv2 : f3[0] ? {2{rv2[15:0]}} : {4{rv2[7:0]}};
    assign st_strb = f3[1] ? 4'hF : f3[0] ? (ea[1] ? 4'hC : 4'h3) : 4'b0001 << ea[1:0];
`else
    assign ld_ok   = f3 == 3'd2;
    assign st_ok   = f3 == 3'd2;
    assign ld_data = mem_rdata;
    assign st_data = rv2;
    assign st_strb = 4'hF;
`endif
    assign legal = !bad_reg && (is_lui || is_auipc || is_jal || (is_jalr && f3 == 3'd0)
                 || (is_br && !(!f3[2] && f3[1])) || (is_ld && ld_ok) || (is_st && st_ok)
                 || (is_opi && opi_ok) || (is_op && op_ok) || (is_fence && f3 == 3'd0));
    assign alu_b = is_op ? rv2 : imm_i;
    always_comb begin
        case (f3)
            3'd0: alu = (is_op && f7[5]) ? rv1 - alu_b : rv1 + alu_b;
            3'd1: alu = rv1 << alu_b[4:0];
            3'd2: alu = {31'd0, $signed(rv1) < $signed(alu_b)};
            3'd3: alu = {31'd0, rv1 < alu_b};
            3'd4: alu = rv1 ^ alu_b;
            3'd5: alu = f7[5] ? $unsigned($signed(rv1) >>> alu_b[4:0]) : rv1 >> alu_b[4:0];
            3'd6: alu = rv1 | alu_b;
            default: alu = rv1 & alu_b;
        endcase
    end
    // f3[0] inverts the base compare (NE/GE/GEU)
    assign br_take = (f3[2] ? (f3[1] ? rv1 < rv2 : $signed(rv1) < $signed(rv2)) : rv1 == rv2) ^ f3[0];
    assign pc4 = pc_q + 32'd4;
    assign jt = is_jal ? pc_q + imm_j : is_jalr ? (rv1 + imm_i) & ~32'd1 : pc_q + imm_b;
    assign jump = is_jal | is_jalr | (is_br & br_take);
    assign mis_tgt = jump & jt[1];
    assign ea = rv1 + (is_st ? imm_s : imm_i);
    assign mis_data = f3[1] ? ea[1:0] != 2'd0 : f3[0] & ea[0];
    assign wb = is_lui ? imm_u : is_auipc ? pc_q + imm_u : (is_jal | is_jalr) ? pc4 : alu;
    assign halted = state_q == HALT;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rf_we     = 1'b0;
        rf_wd     = wb;
        retire    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = {ea[31:2], 2'b00};
        mem_wstrb = 4'h0;
        mem_wdata = st_data;
        case (state_q)
            FETCH: begin
                mem_valid = !rst;
                mem_instr = 1'b1;
                mem_addr  = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!legal || mis_tgt || (is_mem && mis_data)) state_d = HALT;
                else if (is_mem) state_d = MEM;
                else begin
                    rf_we   = use_rd;
                    pc_d    = jump ? jt : pc4;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                mem_valid = !rst;
                mem_wstrb = is_st ? st_strb : 4'h0;
                if (mem_ready) begin
                    rf_we   = is_ld;
                    rf_wd   = ld_data;
                    pc_d    = pc4;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            HALT: state_d = HALT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0) rf_q[rd[AW-1:0]] <= rf_wd;
    end
endmodule

// File: tb/tb_furv_mc.sv
// tb_furv_mc: scoreboard bench for furv_mc with a wait-state memory model
// and a second RV32E instance for the register-range check.
module tb_furv_mc;
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } tr_t;
    logic        clk = 0, rst = 1;
    logic        mem_valid, mem_ready = 0, mem_instr, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [3:0]  mem_wstrb;
    logic        mem_valid2, mem_instr2, retire2, halted2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;
    logic [3:0]  mem_wstrb2;
    logic [31:0] mem [256];
    tr_t         exp_q [$];
    int          lat_q [$];
    tr_t         cap;
    int          checks = 0, fails = 0;
    int          cyc = 0, wcnt = 0, wait_cfg = 0, fstart = 0, ret2 = 0;
    logic        pend = 0;

    furv_mc #(.RESET_PC(32'h100), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .retire(retire), .halted(halted));
    furv_mc #(.RESET_PC(32'h0), .NREGS(16)) dut_e (
        .clk(clk), .rst(rst), .mem_valid(mem_valid2), .mem_ready(1'b1), .mem_instr(mem_instr2),
        .mem_addr(mem_addr2), .mem_wstrb(mem_wstrb2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .retire(retire2), .halted(halted2));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
        logic [31:0] m, d, o;
        m = imm; d = rd; o = op;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction
    localparam logic [31:0] ECALL = 32'h0000_0073;

    assign mem_rdata2 = (mem_addr2 == 32'h0) ? enc_i(1, 0, 0, 15, 'h13) : enc_i(1, 0, 0, 17, 'h13);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask
    task automatic ef(input logic [31:0] a);
        exp_q.push_back('{1'b1, a, 4'h0, 32'h0});
    endtask
    task automatic el(input logic [31:0] a);
        exp_q.push_back('{1'b0, a, 4'h0, 32'h0});
    endtask
    task automatic es(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_q.push_back('{1'b0, a, s, d});
    endtask
    task automatic put(input int a, input logic [31:0] w);
        mem[a >> 2] = w;
    endtask

    // memory responder and transfer scoreboard
    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 0; wcnt = 0; pend = 0; cyc = 0;
        end else begin
            cyc++;
            if (mem_ready) begin wcnt = 0; pend = 0; end
            mem_ready = 0;
            if (mem_valid) begin
                if (!pend) begin
                    pend = 1;
                    cap = '{mem_instr, mem_addr, mem_wstrb, mem_wdata};
                    if (mem_instr) fstart = cyc;
                end else begin
                    chk("hold_addr", mem_addr, cap.addr);
                    chk("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, cap.wstrb});
                    chk("hold_wdata", mem_wdata, cap.wdata);
                    chk("hold_instr", {31'd0, mem_instr}, {31'd0, cap.instr});
                end
                if (wcnt >= wait_cfg) begin
                    logic [31:0] word;
                    tr_t e;
                    mem_ready = 1;
                    word = mem[mem_addr[9:2]];
                    mem_rdata = word;
                    for (int b = 0; b < 4; b++) if (mem_wstrb[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem[mem_addr[9:2]] = word;
                    if (exp_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_xfer: got addr %h, required no transfer", mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_instr", {31'd0, mem_instr}, {31'd0, e.instr});
                        chk("xfer_addr", mem_addr, e.addr);
                        chk("xfer_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                        if (e.wstrb != 0) chk("xfer_wdata", mem_wdata, e.wdata);
                    end
                end else wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && retire) begin
            if (lat_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_retire: got pulse at cycle %0d, required none", cyc);
            end else chk("retire_latency", cyc - fstart, lat_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst) ret2 = 0;
        else if (retire2) ret2++;
    end

    task automatic begin_test(input int w);
        @(posedge clk); #2;
        rst = 1; #1;
        chk("rst_async_valid", {31'd0, mem_valid}, 0);
        exp_q.delete(); lat_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 0;
        wait_cfg = w;
    endtask
    task automatic release_rst();
        repeat (3) begin
            @(negedge clk); #2;
            chk("rst_valid", {31'd0, mem_valid}, 0);
            chk("rst_retire", {31'd0, retire}, 0);
            chk("rst_halted", {31'd0, halted}, 0);
        end
        @(posedge clk); #2 rst = 0;
        @(negedge clk); #2;
        chk("first_fetch_valid", {31'd0, mem_valid}, 1);
        chk("first_fetch_instr", {31'd0, mem_instr}, 1);
    endtask
    task automatic finish_run();
        int n = 0;
        while (!halted && n < 400) begin @(negedge clk); n++; end
        chk("halt_reached", {31'd0, halted}, 1);
        repeat (4) begin
            @(negedge clk); #2;
            chk("halt_valid", {31'd0, mem_valid}, 0);
            chk("halt_retire", {31'd0, retire}, 0);
            chk("halt_sticky", {31'd0, halted}, 1);
        end
        chk("exp_left", exp_q.size(), 0);
        chk("lat_left", lat_q.size(), 0);
    endtask

    initial begin
        // ALU sequence, no wait states
        begin_test(0);
        put('h100, enc_i(-1, 0, 0, 1, 'h13));
        put('h104, enc_i(28, 1, 5, 2, 'h13));
        put('h108, enc_r(0, 2, 1, 2, 3));
        put('h10C, enc_s(0, 1, 0, 2));
        put('h110, enc_s(4, 2, 0, 2));
        put('h114, enc_s(8, 3, 0, 2));
        put('h118, ECALL);
        ef('h100); ef('h104); ef('h108); ef('h10C); es('h0, 4'hF, 32'hFFFF_FFFF);
        ef('h110); es('h4, 4'hF, 32'h0000_000F); ef('h114); es('h8, 4'hF, 32'h1); ef('h118);
        lat_q = '{1, 1, 1, 2, 2, 2};
        release_rst();
        finish_run();
        chk("rv32e_halted", {31'd0, halted2}, 1);
        chk("rv32e_retires", ret2, 1);
        // store then load with 3 wait states per access
        begin_test(3);
        put('h100, enc_u('h12345, 5, 'h37));
        put('h104, enc_i('h678, 5, 0, 5, 'h13));
        put('h108, enc_s('h40, 5, 0, 2));
        put('h10C, enc_i('h40, 0, 2, 6, 'h03));
        put('h110, enc_s('h44, 6, 0, 2));
        put('h114, ECALL);
        ef('h100); ef('h104); ef('h108); es('h40, 4'hF, 32'h1234_5678);
        ef('h10C); el('h40); ef('h110); es('h44, 4'hF, 32'h1234_5678); ef('h114);
        lat_q = '{4, 4, 8, 8, 8};
        release_rst();
        finish_run();
        // branches and jumps
        begin_test(0);
        put('h100, enc_i(5, 0, 0, 1, 'h13));
        put('h104, enc_b(8, 1, 1, 0));
        put('h108, ECALL);
        put('h10C, enc_b(8, 1, 1, 1));
        put('h110, enc_j(-240, 0));
        put('h20, enc_j(12, 1));
        put('h24, ECALL);
        put('h2C, enc_s('h48, 1, 0, 2));
        put('h30, ECALL);
        ef('h100); ef('h104); ef('h10C); ef('h110); ef('h20); ef('h2C); es('h48, 4'hF, 32'h24); ef('h30);
        lat_q = '{1, 1, 1, 1, 1, 2};
        release_rst();
        finish_run();
        // byte store and loads
        begin_test(1);
        put('h100, enc_i('hA5, 0, 0, 1, 'h13));
        put('h104, enc_i('h43, 0, 0, 2, 'h13));
        put('h108, enc_s(0, 1, 2, 0));
`ifdef FURV_MC_SUBWORD_EN
        put('h10C, enc_i(0, 2, 0, 3, 'h03));
        put('h110, enc_i(0, 2, 4, 4, 'h03));
        put('h114, enc_s('h50, 3, 0, 2));
        put('h118, enc_s('h54, 4, 0, 2));
        put('h11C, ECALL);
        ef('h100); ef('h104); ef('h108); es('h40, 4'b1000, 32'hA5A5_A5A5);
        ef('h10C); el('h40); ef('h110); el('h40);
        ef('h114); es('h50, 4'hF, 32'hFFFF_FFA5); ef('h118); es('h54, 4'hF, 32'h0000_00A5); ef('h11C);
        lat_q = '{2, 2, 4, 4, 4, 4, 4};
`else
        ef('h100); ef('h104); ef('h108);
        lat_q = '{2, 2};
`endif
        release_rst();
        finish_run();
        // misaligned word load
        begin_test(0);
        put('h100, enc_i('h42, 0, 0, 1, 'h13));
        put('h104, enc_i(0, 1, 2, 2, 'h03));
        ef('h100); ef('h104);
        lat_q = '{1};
        release_rst();
        finish_run();
        // JALR to a target with bit 1 set
        begin_test(0);
        put('h100, enc_i('h203, 0, 0, 1, 'h13));
        put('h104, enc_i(0, 1, 0, 0, 'h67));
        ef('h100); ef('h104);
        lat_q = '{1};
        release_rst();
        finish_run();
        // reset while a fetch is waiting, then a lone ECALL
        begin_test(6);
        put('h100, enc_i(1, 0, 0, 1, 'h13));
        release_rst();
        repeat (2) @(negedge clk);
        begin_test(0);
        put('h100, ECALL);
        ef('h100);
        release_rst();
        finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
